// File: rtl/spike_event_gen.sv
// spike_event_gen
// Decides whether each incoming neuron sample fires, writes back the
// (possibly reset) membrane potential one cycle later, tracks a per-neuron
// refractory window and queues spike events {timestep, neuron_id} in a FIFO.

module spike_event_gen #(
  parameter int          NUM_NEURONS = 30,
  parameter logic [3:0]  REFRACT     = 4'd2,
  parameter logic [31:0] V_RESET     = 32'h00000000,
  parameter int          FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_id,
  input  logic [31:0] in_potential,
  input  logic        in_greater,
  input  logic        time_step,
  output logic        pot_valid,
  output logic [4:0]  pot_id,
  output logic [31:0] pot_out,
  output logic        spike,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [15:0] evt_data
);

  localparam int              AW         = $clog2(FIFO_DEPTH);
  localparam int              CW         = AW + 1;
  localparam logic [5:0]      NUM_LIMIT  = 6'(NUM_NEURONS);
  localparam logic [CW-1:0]   FULL_COUNT = CW'(FIFO_DEPTH);

  logic [3:0]    refr_r [NUM_NEURONS];
  logic [10:0]   ts_r;
  logic [15:0]   fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  logic          accept_s;
  logic          in_range_s;
  logic          refractory_s;
  logic          fire_s;
  logic          push_s;
  logic          pop_s;
  logic [3:0]    refr_cur_s;

  // Handshake status derived from the registered FIFO occupancy.
  assign in_ready  = (count_r != FULL_COUNT);
  assign evt_valid = (count_r != {CW{1'b0}});
  assign evt_data  = fifo_mem_r[rd_ptr_r];

  // Classify the presented sample: in range, refractory, fires.
  always_comb begin
    in_range_s = ({1'b0, in_id} < NUM_LIMIT);
    if (in_range_s) begin
      refr_cur_s = refr_r[in_id];
    end else begin
      refr_cur_s = 4'd0;
    end
    accept_s     = in_valid && in_ready;
    refractory_s = (refr_cur_s != 4'd0);
    fire_s       = accept_s && in_greater && in_range_s && !refractory_s;
    push_s       = fire_s;
    pop_s        = evt_valid && evt_ready;
  end

  // Registered write-back: one cycle after each accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      pot_valid <= 1'b0;
      spike     <= 1'b0;
      pot_id    <= 5'd0;
      pot_out   <= 32'h00000000;
    end else begin
      pot_valid <= accept_s;
      spike     <= fire_s;
      if (accept_s) begin
        pot_id <= in_id;
        // A firing or still-refractory neuron is clamped to the reset potential.
        if (fire_s || refractory_s) begin
          pot_out <= V_RESET;
        end else begin
          pot_out <= in_potential;
        end
      end
    end
  end

  // Refractory counters: a fire reload wins over the time-step decrement.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (rst) begin
        refr_r[i] <= 4'd0;
      end else if (fire_s && (in_id == 5'(i))) begin
        refr_r[i] <= REFRACT;
      end else if (time_step && (refr_r[i] != 4'd0)) begin
        refr_r[i] <= refr_r[i] - 4'd1;
      end
    end
  end

  // Time-step counter, wrapping naturally at 2047 -> 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_r <= 11'd0;
    end else if (time_step) begin
      ts_r <= ts_r + 11'd1;
    end
  end

  // FIFO pointers and occupancy; push never happens when full since accept needs in_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; event carries the pre-increment time step of the accept cycle.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      fifo_mem_r[wr_ptr_r] <= {ts_r, in_id};
    end
  end

endmodule

// File: doc/spike_event_gen.md
SPIKE_EVENT_GEN -- requirements
Module: spike_event_gen

Interface
REQ-001 Parameter NUM_NEURONS, default 30, number of neurons tracked (neuron ids 0..NUM_NEURONS-1).
REQ-002 Parameter REFRACT, default 4'd2, refractory length in time steps after a spike.
REQ-003 Parameter V_RESET, default 32'h00000000, IEEE-754 single reset potential.
REQ-004 Parameter FIFO_DEPTH, default 8, spike event FIFO entries (power of two).
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  neuron sample present.
REQ-008 in_ready  output  1  block accepts a sample this cycle.
REQ-009 in_id  input  5  neuron id of the sample.
REQ-010 in_potential  input  32  updated membrane potential, FP32.
REQ-011 in_greater  input  1  upstream FP comparator result, 1 when in_potential > threshold.
REQ-012 time_step  input  1  one-cycle pulse marking end of an SNN time step.
REQ-013 pot_valid  output  1  write-back sample valid.
REQ-014 pot_id  output  5  id of write-back sample.
REQ-015 pot_out  output  32  potential to write back to neuron memory.
REQ-016 spike  output  1  write-back sample fired.
REQ-017 evt_valid  output  1  spike event available at FIFO head.
REQ-018 evt_ready  input  1  consumer takes head event.
REQ-019 evt_data  output  16  {timestep[10:0], neuron_id[4:0]}.

Function
REQ-020 Sample accepted when in_valid && in_ready; in_ready SHALL equal !fifo_full (combinational from registered count).
REQ-021 Write-back outputs SHALL be registered, 1-cycle latency: pot_valid high the cycle after each accept, low otherwise; pot_id = accepted in_id.
REQ-022 Per-neuron 4-bit refractory counter refr[id]; fire condition = in_greater && refr[in_id]==0 && in_id<NUM_NEURONS.
REQ-023 On fire: spike=1, pot_out=V_RESET, refr[in_id] <= REFRACT, event {ts, in_id} pushed to FIFO in the accept cycle.
REQ-024 No fire, refr[in_id]!=0: spike=0, pot_out=V_RESET (potential clamped during refractory).
REQ-025 No fire, refr[in_id]==0: spike=0, pot_out=in_potential unchanged.
REQ-026 in_id >= NUM_NEURONS: spike=0, pot_out=in_potential, no push, no counter change; pot_valid still asserted.
REQ-027 11-bit timestep counter ts increments on time_step, wraps 2047->0; every nonzero refr[] decrements by 1 on time_step.
REQ-028 time_step coincident with accept: sample evaluated with pre-decrement refr and pre-increment ts; a fire load of REFRACT overrides that neuron's decrement.
REQ-029 FIFO: push on fire, pop on evt_valid && evt_ready; evt_valid = !empty; evt_data = head entry, stable while evt_valid && !evt_ready.
REQ-030 Simultaneous push and pop SHALL both occur, count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-031 Full FIFO deasserts in_ready, so no event is ever dropped; pop while full re-enables in_ready next cycle.
REQ-032 Pop on empty and accept while in_ready=0 SHALL be ignored.

Reset
REQ-033 rst SHALL clear ts, all refr[], FIFO pointers and count, pot_valid, spike, pot_id, pot_out to 0; evt_valid=0, in_ready=1 the cycle after rst.
REQ-034 rst mid-operation SHALL discard queued events and any in-flight write-back; rst has priority over all other inputs.

Verification
REQ-035 Reset, id 3, pot 32'h40000000, greater=1 -> next cycle pot_valid=1, spike=1, pot_out=0; evt_data=16'h0003.
REQ-036 Same id 3 greater=1 again before time_step -> spike=0, pot_out=0; after 2 time_step pulses -> greater=1 fires with evt_data={11'd2,5'd3}.
REQ-037 Nine fires with evt_ready=0 -> 8 events queued, in_ready=0 after 8th; one pop -> in_ready=1 next cycle, order preserved.
REQ-038 time_step same cycle as fire of id 5 at refr=0 -> refr[5]=REFRACT (not REFRACT-1), event carries pre-increment ts.
REQ-039 in_id=31, greater=1 -> spike=0, pot_out=in_potential, FIFO count unchanged.
REQ-040 2048 time_step pulses -> ts wraps to 0; rst with 3 queued events -> evt_valid=0 next cycle.
